// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
// Module      : stack_unit
// Description : 8-entry LIFO for CALL/RET and PUSH/POP traffic. Provides a
//               combinational top-of-stack read, SC index for the stack
//               display decoder, EMPTY/FULL status and optional sticky
//               OVF/UNF error flags (enabled by defining STK_ERR_FLAGS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module stack_unit #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PUSH,
  input  logic                  POP,
  input  logic                  CLR,
  input  logic [DATA_WIDTH-1:0] DIN,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic [2:0]            SC,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  OVF,
  output logic                  UNF
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [3:0] C_FULL_COUNT = 4'(DEPTH);

  state_t                state_q, state_d;
  logic [3:0]            count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  wr_en_d;
  logic [2:0]            wr_addr_d;
  logic [2:0]            tos_idx;

  // Status decode comes straight from the registered state.
  assign EMPTY   = (state_q == S_EMPTY);
  assign FULL    = (state_q == S_FULL);
  // Low three bits minus one: COUNT=8 maps to 7, so SC never wraps while full.
  assign tos_idx = count_q[2:0] - 3'd1;
  assign SC      = EMPTY ? 3'd0 : tos_idx;
  assign DOUT    = EMPTY ? '0 : mem_q[tos_idx];

  // Next-state logic: CLR beats PUSH/POP; simultaneous PUSH+POP rewrites TOS.
  always_comb begin
    count_d   = count_q;
    state_d   = state_q;
    wr_en_d   = 1'b0;
    wr_addr_d = count_q[2:0];
    if (CLR) begin
      count_d = 4'd0;
    end else begin
      unique case ({PUSH, POP})
        2'b10: begin
          if (state_q != S_FULL) begin
            wr_en_d = 1'b1;
            count_d = count_q + 4'd1;
          end
        end
        2'b01: begin
          if (state_q != S_EMPTY) begin
            count_d = count_q - 4'd1;
          end
        end
        2'b11: begin
          wr_en_d = 1'b1;
          if (state_q == S_EMPTY) begin
            wr_addr_d = 3'd0;
            count_d   = 4'd1;
          end else begin
            wr_addr_d = tos_idx;
          end
        end
        default: ;
      endcase
    end
    if (count_d == 4'd0) begin
      state_d = S_EMPTY;
    end else if (count_d == C_FULL_COUNT) begin
      state_d = S_FULL;
    end else begin
      state_d = S_PART;
    end
  end

  // Occupancy and state registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= 4'd0;
      state_q <= S_EMPTY;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  // Entry storage is never cleared; a reset cycle blocks any write.
  always_ff @(posedge CLK) begin
    if (wr_en_d && !RST) begin
      mem_q[wr_addr_d] <= DIN;
    end
  end

`ifdef STK_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  // Sticky error flags: set on an ignored push/pop, cleared by RST or CLR.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (PUSH && !POP && (state_q == S_FULL)) begin
        ovf_q <= 1'b1;
      end
      if (POP && !PUSH && (state_q == S_EMPTY)) begin
        unf_q <= 1'b1;
      end
    end
  end

  assign OVF = ovf_q;
  assign UNF = unf_q;
`else
  assign OVF = 1'b0;
  assign UNF = 1'b0;
`endif

endmodule
`default_nettype wire
